// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline boundary: a 2-entry skid buffer with a registered ready signal.
// The head entry drives MEM and the EX forwarding port. A saturating counter counts MEM stall cycles.
module ex_mem_skid_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_alu_out,
  input  logic [XLEN-1:0]        in_store_data,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [4:0]             in_rd,
  input  logic                   in_reg_write,
  input  logic [2:0]             in_load_type,
  input  logic [3:0]             in_store_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_alu_out,
  output logic [XLEN-1:0]        out_store_data,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rd,
  output logic                   out_reg_write,
  output logic [2:0]             out_load_type,
  output logic [3:0]             out_store_mask,
  output logic                   fwd_valid,
  output logic [4:0]             fwd_rd,
  output logic [XLEN-1:0]        fwd_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic [2:0]      load_type;
    logic [3:0]      store_mask;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  entry_t                 main_q, main_d;
  entry_t                 skid_q, skid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{alu_out:    in_alu_out,
                      store_data: in_store_data,
                      pc:         in_pc,
                      rd:         in_rd,
                      reg_write:  in_reg_write,
                      load_type:  in_load_type,
                      store_mask: in_store_mask};

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end

    // A flush wins over every other event. A head entry that is consumed in the same cycle still counts as delivered to MEM.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_alu_out    = main_q.alu_out;
  assign out_store_data = main_q.store_data;
  assign out_pc         = main_q.pc;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_load_type  = main_q.load_type;
  assign out_store_mask = main_q.store_mask;

  // x0 is hardwired to zero, so a head entry that targets it is never a forwarding source.
  assign fwd_valid = out_valid & main_q.reg_write & (main_q.rd != 5'd0);
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.alu_out;
  assign stall_cnt = stall_cnt_q;

endmodule
